led_flash_seq: RTL and testbench
================================

// Module: led_flash_seq
// PURPOSE
//  Parametrised LED flash sequencer for the game's coloured button LEDs.
//  Each accepted command lights exactly one of NUM_LEDS LEDs (one-hot) for a timed ON window then a dark GAP, or holds it lit.
//  Reports busy/done so the game controller can play a pattern one step at a time.
//  Sits between the game controller and the board LED pins.
// PARAMETERS
//  NUM_LEDS   4           number of LED channels (2..16)
//  IDX_W      2           width of colour index; must be >= clog2(NUM_LEDS)
//  ON_CYCLES  12_500_000  clock cycles an LED stays lit per timed flash (>=1)
//  GAP_CYCLES 5_000_000   dark cycles after ON before done (0 = no gap)
//  CNT_W      32          timer width; must hold max(ON_CYCLES,GAP_CYCLES)
//  PWM_W      4           duty/PWM counter width (used only with LED_PWM_EN)
// PORTS
//  clock      in   1         system clock, all logic on rising edge
//  resetn     in   1         asynchronous, active-low reset
//  flash_led  in   1         command strobe, sampled every rising edge
//  color      in   IDX_W     LED index for the command
//  hold       in   1         1 = static on (no timer), 0 = timed flash
//  clear      in   1         abort; force all LEDs off, return to IDLE
//  leds       out  NUM_LEDS  one-hot LED drive, bit i = channel i (registered)
//  busy       out  1         high while a timed flash (ON or GAP) runs
//  done       out  1         one-cycle pulse when a timed flash completes
//  duty       in   PWM_W     brightness (present only with LED_PWM_EN)
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE, leds=0, busy=0, done=0, timer=0, latched colour=0.
//  States: IDLE, ON, GAP, HOLD. All outputs registered; done defaults 0 each cycle.
//  IDLE: flash_led=1 & color<NUM_LEDS -> latch colour; hold=1 -> HOLD, else ON, timer=0.
//   color>=NUM_LEDS: command dropped, stay IDLE, no done.
//  ON: leds=1<<colour, busy=1; timer++ each cycle; at timer==ON_CYCLES-1 -> GAP (or IDLE+done if GAP_CYCLES=0), timer=0.
//   LED lit exactly ON_CYCLES cycles, first lit cycle = cycle after the strobe edge.
//  GAP: leds=0, busy=1; at timer==GAP_CYCLES-1 -> IDLE, done=1 for the following cycle, busy=0.
//  HOLD: leds=1<<colour, busy=0, indefinitely. New valid flash_led re-latches colour and re-enters HOLD or ON per hold; invalid colour ignored.
//  flash_led during ON/GAP: ignored, not queued.
//  clear=1 in any state: next edge -> IDLE, leds=0, timer=0, no done. clear and flash_led same cycle: clear wins.
//  done and a new strobe in the same cycle: strobe accepted (state is IDLE).
//  Timer never wraps: terminal compare always precedes CNT_W overflow.
// CONFIGURATION
//  LED_PWM_EN defined: adds port duty and a free-running PWM_W counter (reset 0, wraps).
//   Lit channel driven high only while pwm_cnt < duty; duty=0 -> dark, duty=2^PWM_W-1 -> (2^PWM_W-1)/2^PWM_W on.
//   Timing, busy, done unchanged; PWM gates ON and HOLD alike.
//  LED_PWM_EN undefined: no duty port, no PWM counter; lit channel is solid high.
// TESTING  (NUM_LEDS=4, ON_CYCLES=4, GAP_CYCLES=2 unless stated)
//  1 Assert resetn=0 mid-ON -> leds=0, busy=0, done=0 immediately (before next edge).
//  2 Strobe color=2 hold=0 at edge E0 -> leds=4'b0100 for E0..E4, 0 for E4..E6; busy high E0..E6; done high E6..E7 only.
//  3 During test 2 ON, strobe color=1 -> ignored; leds stay 4'b0100, timing unchanged.
//  4 Strobe color=3 hold=1 -> leds=4'b1000 for 100 cycles, busy=0, done never; then strobe color=0 hold=0 -> 4'b0001 timed as test 2.
//  5 clear at 2nd ON cycle -> leds=0 next edge, no done; NUM_LEDS=3 & color=3 strobe -> stays IDLE, leds=0; GAP_CYCLES=0 -> done right after ON.
//  6 LED_PWM_EN, PWM_W=4, duty=4, hold=1 color=1 -> leds[1] high 4 of every 16 cycles; duty=0 -> always 0.

Source files
------------

// File: rtl/led_flash_seq.sv
// led_flash_seq: one-hot LED flash sequencer for the game's button LEDs.
// Each accepted command lights one LED for a timed ON window followed by a
// dark GAP, or holds it lit until the next command or clear.
// Optional feature macro: LED_PWM_EN adds a duty input and a free-running
// PWM counter that gates the lit channel for brightness control.
module led_flash_seq #(
  parameter int NUM_LEDS   = 4,
  parameter int IDX_W      = 2,
  parameter int ON_CYCLES  = 12_500_000,
  parameter int GAP_CYCLES = 5_000_000,
  parameter int CNT_W      = 32
`ifdef LED_PWM_EN
  ,
  parameter int PWM_W      = 4
`endif
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                flash_led,
  input  logic [IDX_W-1:0]    color,
  input  logic                hold,
  input  logic                clear,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]    duty,
`endif
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Terminal counts; a zero-length gap still needs a legal compare value.
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    col_q, col_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept_s;
  logic                lit_s;
  logic                gate_s;

`ifdef LED_PWM_EN
  logic [PWM_W-1:0]    pwm_q, pwm_d;

  // Free-running brightness counter; the lit channel is gated by the value
  // the counter takes on the same edge the LED register updates.
  always_comb begin
    pwm_d  = pwm_q + PWM_W'(1);
    gate_s = (pwm_d < duty);
  end

  // PWM counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  // Without PWM the lit channel is driven solid.
  always_comb begin
    gate_s = 1'b1;
  end
`endif

  // Next-state, timer and registered-output decode.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    col_d    = col_q;
    done_d   = 1'b0;
    accept_s = flash_led && (32'(color) < 32'(NUM_LEDS));
    if (clear) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept_s) begin
            col_d   = color;
            timer_d = '0;
            state_d = hold ? HOLD : ON;
          end else begin
            state_d = state_q;
          end
        end
        ON: begin
          if (timer_q == ON_LAST) begin
            timer_d = '0;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
    lit_s  = (state_d == ON) || (state_d == HOLD);
    busy_d = (state_d == ON) || (state_d == GAP);
    if (lit_s && gate_s) begin
      leds_d = NUM_LEDS'(1) << col_d;
    end else begin
      leds_d = '0;
    end
  end

  // State, timer, colour latch and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      timer_q <= '0;
      col_q   <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      col_q   <= col_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign leds = leds_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_flash_seq.sv
// Testbench for led_flash_seq: three instances (4 LEDs / gap 2, 3 LEDs,
// 4 LEDs / gap 0) share one stimulus stream and are checked every cycle
// against a countdown-based behavioural model.
module tb_led_flash_seq;

  localparam int ONC = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       flash_led = 1'b0;
  logic [1:0] color = 2'd0;
  logic       hold = 1'b0;
  logic       clear = 1'b0;
`ifdef LED_PWM_EN
  logic [3:0] duty = 4'd15;
`endif
  logic [3:0] leds0, leds2;
  logic [2:0] leds1;
  logic       busy0, busy1, busy2, done0, done1, done2;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: lit cycles still to come, dark cycles still to come,
  // held flag, latched colour, done expected this cycle.
  int m_nl[3]   = '{4, 3, 4};
  int m_gap[3]  = '{2, 2, 0};
  int m_col[3];
  int m_lit[3];
  int m_dark[3];
  bit m_held[3];
  bit m_done[3];
  int pcnt;

  led_flash_seq #(.NUM_LEDS(4), .IDX_W(2), .ON_CYCLES(ONC), .GAP_CYCLES(2), .CNT_W(8)) u_dut (
    .clock(clock), .resetn(resetn), .flash_led(flash_led), .color(color), .hold(hold),
    .clear(clear),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .leds(leds0), .busy(busy0), .done(done0));

  led_flash_seq #(.NUM_LEDS(3), .IDX_W(2), .ON_CYCLES(ONC), .GAP_CYCLES(2), .CNT_W(8)) u_dut3 (
    .clock(clock), .resetn(resetn), .flash_led(flash_led), .color(color), .hold(hold),
    .clear(clear),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .leds(leds1), .busy(busy1), .done(done1));

  led_flash_seq #(.NUM_LEDS(4), .IDX_W(2), .ON_CYCLES(ONC), .GAP_CYCLES(0), .CNT_W(8)) u_dutg0 (
    .clock(clock), .resetn(resetn), .flash_led(flash_led), .color(color), .hold(hold),
    .clear(clear),
`ifdef LED_PWM_EN
    .duty(duty),
`endif
    .leds(leds2), .busy(busy2), .done(done2));

  always #5 clock = ~clock;

  function automatic logic [5:0] obs(input int k);
    case (k)
      0:       obs = {leds0, busy0, done0};
      1:       obs = {1'b0, leds1, busy1, done1};
      default: obs = {leds2, busy2, done2};
    endcase
  endfunction

  function automatic logic [5:0] exp_vec(input int k);
    logic [3:0] l;
    bit         lit;
    lit = (m_lit[k] > 0) || m_held[k];
`ifdef LED_PWM_EN
    lit = lit && (pcnt < int'(duty));
`endif
    l = lit ? (4'd1 << m_col[k]) : 4'd0;
    exp_vec = {l, (m_lit[k] > 0) || (m_dark[k] > 0), m_done[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_col[k] = 0; m_lit[k] = 0; m_dark[k] = 0; m_held[k] = 1'b0; m_done[k] = 1'b0;
    end
    pcnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs sampled on it.
  task automatic model_step(input bit f, input int c, input bit h, input bit clr);
    for (int k = 0; k < 3; k++) begin
      m_done[k] = 1'b0;
      if (clr) begin
        m_lit[k] = 0; m_dark[k] = 0; m_held[k] = 1'b0;
      end else if (m_lit[k] > 0) begin
        m_lit[k]--;
        if (m_lit[k] == 0) begin
          m_dark[k] = m_gap[k];
          if (m_gap[k] == 0) m_done[k] = 1'b1;
        end
      end else if (m_dark[k] > 0) begin
        m_dark[k]--;
        if (m_dark[k] == 0) m_done[k] = 1'b1;
      end else if (f && c < m_nl[k]) begin
        m_col[k] = c;
        m_held[k] = h;
        m_lit[k] = h ? 0 : ONC;
      end
    end
`ifdef LED_PWM_EN
    pcnt = (pcnt + 1) % 16;
`endif
  endtask

  task automatic drive_cycle(input bit f, input int c, input bit h, input bit clr);
    flash_led = f; color = 2'(c); hold = h; clear = clr;
    @(posedge clock);
    model_step(f, c, h, clr);
    #1;
    flash_led = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs(k) !== 6'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d got %b want %b", k, obs(k), 6'd0);
      end
    end
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic test_timed();
    drive_cycle(1'b1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL timed cyc%0d inst%0d got %b want %b", i, k, obs(k), exp_vec(k));
        end
      end
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ignore_during_on();
    drive_cycle(1'b1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive_cycle(i < 6, 1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL ignore cyc%0d inst%0d got %b want %b", i, k, obs(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_hold();
    drive_cycle(1'b1, 3, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL hold cyc%0d inst%0d got %b want %b", i, k, obs(k), exp_vec(k));
        end
      end
    end
    drive_cycle(1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL hold_to_timed cyc%0d inst%0d got %b want %b", i, k, obs(k), exp_vec(k));
        end
      end
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_clear_and_invalid();
    drive_cycle(1'b1, 1, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    drive_cycle(1'b1, 2, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL clear cyc%0d inst%0d got %b want %b", i, k, obs(k), exp_vec(k));
        end
      end
      drive_cycle(i == 0, 3, 1'b0, 1'b0);
    end
    n_tests++;
    if (leds1 !== 3'd0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_color leds=%b busy=%b want 000/0", leds1, busy1);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    drive_cycle(1'b1, 0, 1'b0, 1'b0);
    guard = 0;
    while (m_done[0] == 1'b0 && guard < 20) begin
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (guard >= 20 || done0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done got %b want 1 (guard %0d)", done0, guard);
    end
    drive_cycle(1'b1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL b2b cyc%0d inst%0d got %b want %b", i, k, obs(k), exp_vec(k));
        end
      end
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_on();
    drive_cycle(1'b1, 1, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    resetn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs(k) !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_mid_on inst%0d got %b want %b", k, obs(k), 6'd0);
      end
    end
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive_cycle(($urandom % 3) == 0, int'($urandom_range(0, 3)), ($urandom % 4) == 0,
                  ($urandom % 20) == 0);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random cyc%0d inst%0d got %b want %b", i, k, obs(k), exp_vec(k));
        end
      end
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int lit_cnt;
    drive_cycle(1'b0, 0, 1'b0, 1'b1);
    duty = 4'd4;
    drive_cycle(1'b1, 1, 1'b1, 1'b0);
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
      if (leds0[1] === 1'b1) lit_cnt++;
    end
    n_tests++;
    if (lit_cnt != 8) begin
      n_fail++;
      $display("FAIL pwm_duty4 got %0d lit cycles want 8", lit_cnt);
    end
    duty = 4'd0;
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
      if (leds0 !== 4'd0) lit_cnt++;
    end
    n_tests++;
    if (lit_cnt != 0) begin
      n_fail++;
      $display("FAIL pwm_duty0 got %0d lit cycles want 0", lit_cnt);
    end
    duty = 4'd15;
    drive_cycle(1'b0, 0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_timed();
    test_ignore_during_on();
    test_hold();
    test_clear_and_invalid();
    test_back_to_back();
    test_reset_mid_on();
    test_random();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
